// File: rtl/mem_watch_unit.sv
// Memory write watchpoint unit: snoops data-memory writes against per-channel
// address/mode watches and logs time-stamped hit events into a show-ahead FIFO.
module mem_watch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NCH        = 4,
    parameter int CNT_W      = 32,
    parameter int DEPTH      = 8,
    parameter int STOP_AFTER = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_mode,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              evt_rd,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              evt_valid,
    output logic [2:0]        evt_ch,
    output logic [CNT_W-1:0]  evt_cycle,
    output logic [DATA_W-1:0] evt_data,
    output logic              evt_ovf,
    output logic              multi_hit,
    output logic              halt_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ACC_W = (STOP_AFTER < 2) ? 1 : $clog2(STOP_AFTER + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q   [NCH];
    logic [1:0]        mode_q   [NCH];
    logic [DATA_W-1:0] shadow_q [NCH];

    logic [2:0]        fifo_ch_q   [DEPTH];
    logic [CNT_W-1:0]  fifo_cyc_q  [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;

    logic              ovf_q, multi_q, halt_q, halt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic [NCH-1:0]    match, hit;
    logic [2:0]        hit_idx;
    logic              push, pop, store, full, empty, multi;

    // Hits use the configuration registered before this edge.
    always_comb begin
        match = '0;
        hit   = '0;
        for (int i = 0; i < NCH; i++) begin
            match[i] = mem_we && (mem_addr == addr_q[i]);
            case (mode_q[i])
                2'd1:    hit[i] = match[i];
                2'd2:    hit[i] = match[i] && (mem_wdata != shadow_q[i]);
                default: hit[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        hit_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = 3'(i);
        end
    end

    assign multi = (hit & (hit - NCH'(1))) != '0;
    assign push  = |hit;
    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign pop   = evt_rd && !empty;
    assign store = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (store && !pop)      count_d = count_q + (PTR_W + 1)'(1);
        else if (pop && !store) count_d = count_q - (PTR_W + 1)'(1);

        acc_d = acc_q;
        if (store && (acc_q != ACC_W'(STOP_AFTER))) acc_d = acc_q + ACC_W'(1);
        halt_d = halt_q || ((STOP_AFTER != 0) && (acc_d == ACC_W'(STOP_AFTER)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            multi_q  <= 1'b0;
            halt_q   <= 1'b0;
            acc_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                addr_q[i]   <= '0;
                mode_q[i]   <= 2'd0;
                shadow_q[i] <= '0;
            end
        end else begin
            if (en) cnt_q <= cnt_q + CNT_W'(1);
            for (int i = 0; i < NCH; i++) begin
                if (cfg_we && (cfg_ch == 3'(i))) begin
                    addr_q[i]   <= cfg_addr;
                    mode_q[i]   <= cfg_mode;
                    shadow_q[i] <= '0;
                end else if (match[i]) begin
                    shadow_q[i] <= mem_wdata;
                end
            end
            if (store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (push && !store) ovf_q <= 1'b1;
            if (multi)          multi_q <= 1'b1;
            acc_q  <= acc_d;
            halt_q <= halt_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (store) begin
            fifo_ch_q[wr_ptr_q]   <= hit_idx;
            fifo_cyc_q[wr_ptr_q]  <= cnt_q;
            fifo_data_q[wr_ptr_q] <= mem_wdata;
        end
    end

    assign cycle_cnt = cnt_q;
    assign evt_valid = !empty;
    assign evt_ch    = empty ? '0 : fifo_ch_q[rd_ptr_q];
    assign evt_cycle = empty ? '0 : fifo_cyc_q[rd_ptr_q];
    assign evt_data  = empty ? '0 : fifo_data_q[rd_ptr_q];
    assign evt_ovf   = ovf_q;
    assign multi_hit = multi_q;
    assign halt_req  = halt_q;

endmodule

// File: doc/mem_watch_unit.md
MEM_WATCH_UNIT -- requirements
Module: mem_watch_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, memory address width; DATA_W, default 32, write-data width; NCH, default 4, watch channels (1..8); CNT_W, default 32, cycle counter width; DEPTH, default 8, event FIFO depth (power of 2, >=2); STOP_AFTER, default 0, accepted-event count that raises halt_req (0 = never).
REQ-002 One clock; reset is asynchronous and active-low; ports SHALL be named clk and rst.
REQ-003 Ports SHALL be (name direction width meaning):
 clk  in  1  clock, rising edge
 rst  in  1  async active-low reset
 en  in  1  cycle counter enable
 cfg_we  in  1  channel config write strobe
 cfg_ch  in  3  channel index for config write
 cfg_addr  in  ADDR_W  watched address
 cfg_mode  in  2  0 off, 1 any write, 2 value change, 3 reserved (treated as off)
 mem_we  in  1  data-memory write strobe being snooped
 mem_addr  in  ADDR_W  data-memory write address
 mem_wdata  in  DATA_W  data-memory write data
 evt_rd  in  1  pop head event
 cycle_cnt  out  CNT_W  free-running cycle count
 evt_valid  out  1  FIFO non-empty
 evt_ch  out  3  channel of head event
 evt_cycle  out  CNT_W  cycle_cnt at head event's write
 evt_data  out  DATA_W  write data of head event
 evt_ovf  out  1  sticky: event dropped, FIFO full
 multi_hit  out  1  sticky: >1 channel hit in one cycle
 halt_req  out  1  sticky stop request to bench/processor

Function
REQ-004 cycle_cnt SHALL increment by 1 each clk edge with en=1, hold with en=0, wrap from 2^CNT_W-1 to 0.
REQ-005 cfg_we SHALL load addr/mode of channel cfg_ch at the clock edge, effective next cycle; cfg_ch>=NCH SHALL be ignored.
REQ-006 A config write SHALL clear that channel's shadow value to 0.
REQ-007 Channel hit (mode 1): mem_we=1 and mem_addr==channel addr.
REQ-008 Channel hit (mode 2): as mode 1 and mem_wdata != channel shadow; shadow SHALL update to mem_wdata on every address-matching write, hit or not.
REQ-009 Hits SHALL be evaluated against configuration held before the edge; same-cycle cfg_we does not affect that cycle's hit.
REQ-010 At most one event per cycle SHALL be pushed: lowest-index hitting channel; if >=2 channels hit, multi_hit SHALL set.
REQ-011 Event record = {channel, cycle_cnt value sampled in the hit cycle (pre-increment), mem_wdata}.
REQ-012 Pushed event SHALL appear at FIFO outputs the cycle after the hit (1-cycle latency); FIFO is show-ahead, evt_* valid whenever evt_valid=1.
REQ-013 evt_rd with evt_valid=1 SHALL pop; evt_rd when empty SHALL be ignored.
REQ-014 Full FIFO: push with simultaneous pop SHALL succeed; push without pop SHALL be dropped and set evt_ovf.
REQ-015 Empty FIFO with push and evt_rd same cycle: pop ignored, event stored.
REQ-016 Accepted-event counter (saturating at STOP_AFTER) SHALL count pushes that are stored; when it reaches STOP_AFTER!=0, halt_req SHALL assert the following cycle and stay high until reset.
REQ-017 Dropped events SHALL NOT count toward STOP_AFTER.

Reset
REQ-018 rst=0 SHALL immediately clear cycle_cnt, FIFO (evt_valid=0), evt_ovf, multi_hit, halt_req, accepted count, all channel modes to off, addrs and shadows to 0; evt_ch/evt_cycle/evt_data read 0.
REQ-019 Reset asserted mid-operation SHALL discard all pending events; first counted cycle after release yields cycle_cnt=1.

Verification
REQ-020 Ch0 addr 3 mode 1, en=1; write 0x55 to addr 3 when cycle_cnt=10 -> next cycle evt_valid=1, evt_ch=0, evt_cycle=10, evt_data=0x55.
REQ-021 Ch1 addr 3 mode 2; write 7, 7, 9 to addr 3 -> exactly two events, data 7 then 9.
REQ-022 Ch0 and ch2 both addr 8 mode 1; one write -> single event evt_ch=0, multi_hit=1.
REQ-023 DEPTH=8, no pops, 9 hits -> 8 events stored in order, evt_ovf=1; 9th hit with evt_rd at full -> stored, evt_ovf unchanged.
REQ-024 STOP_AFTER=3, 3 hits on cycles 5,6,7 -> halt_req=0 through cycle 7 edge, 1 from next cycle, stays 1.
REQ-025 CNT_W=4, en=1 for 17 cycles -> cycle_cnt 15 then 0 then 1; rst pulse mid-FIFO-content -> evt_valid=0 immediately.
